// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_ctrl_pkg;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_MDU = 1'b1
  } state_e;

  localparam int unsigned ZERO_REG = 0;

  typedef struct packed {
    logic we;
    logic kill;
  } stage_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_mdu_wait_cnt.sv
// rtl/hazard_ctrl_mdu_wait_cnt.sv - loadable down-counter tracking remaining MDU cycles in EX
module mdu_wait_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  input  logic             freeze_i,
  output logic             is_zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Freeze dominates so a memory wait holds the MDU countdown in place.
  always_comb begin
    cnt_d = cnt_q;
    if (freeze_i) begin
      cnt_d = cnt_q;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_zero_o = (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/bubble controller for load-use, branch, MDU and memory-wait hazards
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MDU_LAT    = 32,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_mdu_op,
  input  logic                  ex_branch_taken,
  input  logic                  mem_stall,
  output logic                  pc_we,
  output logic                  we_ifid,
  output logic                  we_idex,
  output logic                  we_exmem,
  output logic                  we_memwb,
  output logic                  kill_ifid,
  output logic                  kill_idex,
  output logic                  kill_exmem,
  output logic                  mdu_busy,
  output logic                  mdu_last,
  output logic [31:0]           stall_cycles
);

  state_e      state_q, state_d;
  stage_ctrl_t ifid, idex, exmem;
  logic        memwb_we;
  logic        cnt_load, cnt_dec, cnt_zero;
  logic        load_use;
  logic [31:0] stall_q, stall_d;

  assign load_use = ex_valid && ex_mem_read && (ex_rd != REG_ADDR_W'(ZERO_REG)) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  always_comb begin
    state_d  = state_q;
    pc_we    = 1'b1;
    ifid     = '{we: 1'b1, kill: 1'b0};
    idex     = '{we: 1'b1, kill: 1'b0};
    exmem    = '{we: 1'b1, kill: 1'b0};
    memwb_we = 1'b1;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    mdu_last = 1'b0;
    if (rst) begin
      pc_we    = 1'b0;
      ifid.we  = 1'b0;
      idex.we  = 1'b0;
      exmem.we = 1'b0;
      memwb_we = 1'b0;
    end else if (mem_stall) begin
      pc_we    = 1'b0;
      ifid.we  = 1'b0;
      idex.we  = 1'b0;
      exmem.we = 1'b0;
      memwb_we = 1'b0;
    end else if (state_q == ST_RUN) begin
      if (ex_valid && ex_branch_taken) begin
        ifid.kill = 1'b1;
        idex.kill = 1'b1;
      end else if (ex_valid && ex_mdu_op) begin
        pc_we      = 1'b0;
        ifid.we    = 1'b0;
        idex.we    = 1'b0;
        exmem.kill = 1'b1;
        cnt_load   = 1'b1;
        state_d    = ST_MDU;
      end else if (load_use) begin
        pc_we     = 1'b0;
        ifid.we   = 1'b0;
        idex.kill = 1'b1;
      end
    end else if (!cnt_zero) begin
      pc_we      = 1'b0;
      ifid.we    = 1'b0;
      idex.we    = 1'b0;
      exmem.kill = 1'b1;
      cnt_dec    = 1'b1;
    end else begin
      mdu_last = 1'b1;
      state_d  = ST_RUN;
    end
  end

  // Every frozen PC cycle is counted, memory waits included.
  always_comb begin
    stall_d = stall_q;
    if (!pc_we) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  mdu_wait_cnt #(
    .CNT_W(CNT_W)
  ) u_mdu_wait_cnt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load),
    .load_val_i(CNT_W'(MDU_LAT - 2)),
    .dec_i     (cnt_dec),
    .freeze_i  (mem_stall),
    .is_zero_o (cnt_zero)
  );

  assign we_ifid      = ifid.we;
  assign we_idex      = idex.we;
  assign we_exmem     = exmem.we;
  assign we_memwb     = memwb_we;
  assign kill_ifid    = ifid.kill;
  assign kill_idex    = idex.kill;
  assign kill_exmem   = exmem.kill;
  assign mdu_busy     = !rst && (state_q == ST_MDU);
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed vector bench for hazard_ctrl
module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_rs1_used, id_rs2_used, ex_valid, ex_mem_read, ex_mdu_op;
  logic       ex_branch_taken, mem_stall;

  logic pc_we, we_ifid, we_idex, we_exmem, we_memwb, kill_ifid, kill_idex, kill_exmem;
  logic mdu_busy, mdu_last;
  logic [31:0] stall_cycles;

  logic pc_we2, we_ifid2, we_idex2, we_exmem2, we_memwb2, kill_ifid2, kill_idex2, kill_exmem2;
  logic mdu_busy2, mdu_last2;
  logic [31:0] stall_cycles2;

  logic [7:0] o8, o8b;
  assign o8  = {pc_we, we_ifid, we_idex, we_exmem, we_memwb, kill_ifid, kill_idex, kill_exmem};
  assign o8b = {pc_we2, we_ifid2, we_idex2, we_exmem2, we_memwb2, kill_ifid2, kill_idex2, kill_exmem2};

  hazard_ctrl #(.REG_ADDR_W(5), .MDU_LAT(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_valid(ex_valid),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mdu_op(ex_mdu_op),
    .ex_branch_taken(ex_branch_taken), .mem_stall(mem_stall),
    .pc_we(pc_we), .we_ifid(we_ifid), .we_idex(we_idex), .we_exmem(we_exmem),
    .we_memwb(we_memwb), .kill_ifid(kill_ifid), .kill_idex(kill_idex),
    .kill_exmem(kill_exmem), .mdu_busy(mdu_busy), .mdu_last(mdu_last),
    .stall_cycles(stall_cycles)
  );

  hazard_ctrl #(.REG_ADDR_W(5), .MDU_LAT(2), .CNT_W(8)) u_dut2 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_valid(ex_valid),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mdu_op(ex_mdu_op),
    .ex_branch_taken(ex_branch_taken), .mem_stall(mem_stall),
    .pc_we(pc_we2), .we_ifid(we_ifid2), .we_idex(we_idex2), .we_exmem(we_exmem2),
    .we_memwb(we_memwb2), .kill_ifid(kill_ifid2), .kill_idex(kill_idex2),
    .kill_exmem(kill_exmem2), .mdu_busy(mdu_busy2), .mdu_last(mdu_last2),
    .stall_cycles(stall_cycles2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1u;
    logic       rs2u;
    logic       exv;
    logic [4:0] rd;
    logic       mr;
    logic       mdu;
    logic       br;
    logic       ms;
    logic [7:0] e8;
  } vec_t;

  vec_t vecs [13];

  // Output byte order: pc_we, we_ifid, we_idex, we_exmem, we_memwb, kill_ifid, kill_idex, kill_exmem
  localparam logic [7:0] DEF = 8'hF8;
  localparam logic [7:0] LDU = 8'h3A;
  localparam logic [7:0] BRN = 8'hFE;
  localparam logic [7:0] MDS = 8'h19;
  localparam logic [7:0] ALL0 = 8'h00;

  task automatic idle_inputs();
    id_rs1 = '0; id_rs2 = '0; id_rs1_used = 0; id_rs2_used = 0;
    ex_valid = 0; ex_rd = '0; ex_mem_read = 0; ex_mdu_op = 0;
    ex_branch_taken = 0; mem_stall = 0;
  endtask

  task automatic cyc(input string nm, input logic r, input logic exv, input logic mdu,
                     input logic ms, input logic [7:0] e8, input logic eb, input logic el,
                     input bit d2);
    @(negedge clk);
    idle_inputs();
    rst = r; ex_valid = exv; ex_mdu_op = mdu; mem_stall = ms;
    #1;
    if (d2) chk(nm, 32'({o8b, mdu_busy2, mdu_last2}), 32'({e8, eb, el}));
    else    chk(nm, 32'({o8, mdu_busy, mdu_last}), 32'({e8, eb, el}));
  endtask

  task automatic do_reset();
    cyc("reset_out", 1, 0, 0, 0, ALL0, 0, 0, 0);
    cyc("reset_out2", 1, 0, 0, 0, ALL0, 0, 0, 1);
  endtask

  int exp_stall;

  initial begin
    rst = 1'b1;
    idle_inputs();

    //            rs1    rs2   u1 u2 exv rd    mr mdu br ms  exp
    vecs[0]  = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, DEF};
    vecs[1]  = '{5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0, 0, 0, LDU};
    vecs[2]  = '{5'd0, 5'd0, 1, 1, 1, 5'd0, 1, 0, 0, 0, DEF};
    vecs[3]  = '{5'd1, 5'd7, 1, 1, 1, 5'd7, 1, 0, 0, 0, LDU};
    vecs[4]  = '{5'd1, 5'd7, 0, 0, 1, 5'd7, 1, 0, 0, 0, DEF};
    vecs[5]  = '{5'd5, 5'd0, 1, 0, 0, 5'd5, 1, 0, 0, 0, DEF};
    vecs[6]  = '{5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, 0, 0, DEF};
    vecs[7]  = '{5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0, 1, 0, BRN};
    vecs[8]  = '{5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 0, DEF};
    vecs[9]  = '{5'd0, 5'd0, 0, 0, 1, 5'd3, 0, 1, 1, 0, BRN};
    vecs[10] = '{5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0, 0, 1, ALL0};
    vecs[11] = '{5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 0, 1, 1, ALL0};
    vecs[12] = '{5'd4, 5'd4, 1, 1, 1, 5'd5, 1, 0, 0, 0, DEF};

    do_reset();
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("post_reset_stall", stall_cycles, 32'd0);
    chk("post_reset_out", 32'({o8, mdu_busy, mdu_last}), 32'({DEF, 1'b0, 1'b0}));

    exp_stall = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      id_rs1_used = vecs[i].rs1u; id_rs2_used = vecs[i].rs2u;
      ex_valid = vecs[i].exv; ex_rd = vecs[i].rd; ex_mem_read = vecs[i].mr;
      ex_mdu_op = vecs[i].mdu; ex_branch_taken = vecs[i].br; mem_stall = vecs[i].ms;
      #1;
      chk($sformatf("vec%0d_out", i), 32'({o8, mdu_busy, mdu_last}), 32'({vecs[i].e8, 1'b0, 1'b0}));
      chk($sformatf("vec%0d_stall", i), stall_cycles, 32'(exp_stall));
      if (!vecs[i].e8[7]) exp_stall++;
    end
    cyc("vec_tail", 0, 0, 0, 0, DEF, 0, 0, 0);
    chk("vec_stall_total", stall_cycles, 32'(exp_stall));

    // MDU_LAT=4: three stalled cycles then a release with mdu_last.
    do_reset();
    cyc("mdu_entry", 0, 1, 1, 0, MDS, 0, 0, 0);
    cyc("mdu_c2",    0, 1, 1, 0, MDS, 1, 0, 0);
    cyc("mdu_c3",    0, 1, 1, 0, MDS, 1, 0, 0);
    cyc("mdu_rel",   0, 1, 1, 0, DEF, 1, 1, 0);
    cyc("mdu_after", 0, 0, 0, 0, DEF, 0, 0, 0);
    chk("mdu_stall_cnt", stall_cycles, 32'd3);

    // Two memory-wait cycles mid-MDU push the release out by two.
    do_reset();
    cyc("ms_entry", 0, 1, 1, 0, MDS, 0, 0, 0);
    cyc("ms_c2",    0, 1, 1, 0, MDS, 1, 0, 0);
    cyc("ms_w1",    0, 1, 1, 1, ALL0, 1, 0, 0);
    cyc("ms_w2",    0, 1, 1, 1, ALL0, 1, 0, 0);
    cyc("ms_c5",    0, 1, 1, 0, MDS, 1, 0, 0);
    cyc("ms_rel",   0, 1, 1, 0, DEF, 1, 1, 0);
    cyc("ms_after", 0, 0, 0, 0, DEF, 0, 0, 0);
    chk("ms_stall_cnt", stall_cycles, 32'd5);

    // Reset while in MDU returns to RUN; the next op takes the full latency.
    do_reset();
    cyc("rm_entry", 0, 1, 1, 0, MDS, 0, 0, 0);
    cyc("rm_c2",    0, 1, 1, 0, MDS, 1, 0, 0);
    cyc("rm_rst",   1, 1, 1, 0, ALL0, 0, 0, 0);
    cyc("rm_run",   0, 0, 0, 0, DEF, 0, 0, 0);
    chk("rm_stall_zero", stall_cycles, 32'd0);
    cyc("rm2_entry", 0, 1, 1, 0, MDS, 0, 0, 0);
    cyc("rm2_c2",    0, 1, 1, 0, MDS, 1, 0, 0);
    cyc("rm2_c3",    0, 1, 1, 0, MDS, 1, 0, 0);
    cyc("rm2_rel",   0, 1, 1, 0, DEF, 1, 1, 0);
    cyc("rm2_after", 0, 0, 0, 0, DEF, 0, 0, 0);
    chk("rm2_stall_cnt", stall_cycles, 32'd3);

    // Back-to-back MDU ops with MDU_LAT=2.
    do_reset();
    cyc("bb_entry1", 0, 1, 1, 0, MDS, 0, 0, 1);
    cyc("bb_rel1",   0, 1, 1, 0, DEF, 1, 1, 1);
    cyc("bb_entry2", 0, 1, 1, 0, MDS, 0, 0, 1);
    cyc("bb_rel2",   0, 1, 1, 0, DEF, 1, 1, 1);
    cyc("bb_after",  0, 0, 0, 0, DEF, 0, 0, 1);
    chk("bb_stall_cnt", stall_cycles2, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage core. Sits directly upstream of the IF/ID, ID/EX, EX/MEM and MEM/WB `gnrl_dff` stage registers and the PC register. It drives their `write_enable` and a per-stage bubble-insert select, resolving load-use hazards, taken-branch squashes, multi-cycle MDU (mul/div) occupancy of EX, and data-memory wait states. Stage registers' own `flush` inputs are tied low; bubbles are inserted via `kill_*`.

## Interface
- `REG_ADDR_W`, default 5: register-file address width.
- `MDU_LAT`, default 32: total cycles an MDU op occupies EX; legal range 2..255.
- `CNT_W`, default 8: MDU wait-counter width; must satisfy 2^CNT_W > MDU_LAT.
- `clk`  in  1  single clock; everything sampled on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_rs1`, `id_rs2`  in  REG_ADDR_W  source registers of the instruction in ID.
- `id_rs1_used`, `id_rs2_used`  in  1  the ID instruction actually reads rs1/rs2.
- `ex_valid`  in  1  EX holds a real instruction (not a bubble).
- `ex_rd`  in  REG_ADDR_W  destination register of the EX instruction.
- `ex_mem_read`  in  1  EX instruction is a load.
- `ex_mdu_op`  in  1  EX instruction is a mul/div.
- `ex_branch_taken`  in  1  EX resolved a taken branch/jump (redirect).
- `mem_stall`  in  1  data memory not ready this cycle.
- `pc_we`  out  1  PC register write enable.
- `we_ifid`, `we_idex`, `we_exmem`, `we_memwb`  out  1  stage register write enables.
- `kill_ifid`, `kill_idex`, `kill_exmem`  out  1  select the bubble (valid=0) at that register's input; only meaningful with its `we_*`=1.
- `mdu_busy`  out  1  FSM in MDU state.
- `mdu_last`  out  1  final EX cycle of an MDU op; EX commits the result.
- `stall_cycles`  out  32  count of cycles with `pc_we`=0 since reset; wraps.

## Operation
- Outputs are combinational from state and inputs; state, counter and `stall_cycles` are registered.
- States: RUN, MDU. Default outputs: all `we_*`=1, `pc_we`=1, all `kill_*`=0.
- Priority per cycle: `rst` > `mem_stall` > branch > MDU > load-use.
- `rst`: all `we_*`=0, `pc_we`=0, `kill_*`=0, `mdu_busy`=0, `mdu_last`=0. After the edge: state RUN, counter 0, `stall_cycles`=0.
- `mem_stall`: all `we_*`=0, `pc_we`=0. State, counter and all pending decisions are frozen; everything is re-evaluated next cycle.
- Branch (`ex_valid & ex_branch_taken`, RUN): `pc_we`=1, `kill_ifid`=1, `kill_idex`=1. This suppresses any load-use stall the same cycle. If `ex_mdu_op` is also set, the branch wins and no MDU entry occurs.
- MDU entry (RUN, `ex_valid & ex_mdu_op`):
  - `pc_we`=`we_ifid`=`we_idex`=0, `we_exmem`=1 with `kill_exmem`=1.
  - Load counter with MDU_LAT-2; next state MDU.
- MDU state, counter ≠ 0: same stall outputs as entry; counter decrements.
- MDU state, counter = 0 (release): default outputs, `mdu_last`=1, next state RUN.
- Load-use (RUN, `ex_valid & ex_mem_read & ex_rd≠0`, and `id_rs1_used & id_rs1==ex_rd` or `id_rs2_used & id_rs2==ex_rd`):
  - `pc_we`=0, `we_ifid`=0, `we_idex`=1 with `kill_idex`=1; later stages advance.
  - Exactly one bubble per hazard.
- `ex_rd`=0 never causes a hazard.
- `stall_cycles` increments on every non-reset cycle with `pc_we`=0, including `mem_stall` cycles.

## Timing
- Zero-cycle decision latency: outputs act on the same edge as the inputs that cause them.
- Load-use penalty: 1 cycle. Branch penalty: 2 squashed slots, no stall.
- MDU op occupies EX for exactly MDU_LAT cycles (entry + MDU_LAT-1 in MDU). `mdu_busy` is high MDU_LAT-1 cycles; `mdu_last` is high 1 cycle.
- A `mem_stall` during MDU extends the occupancy by one cycle per stalled cycle.
- Back-to-back MDU ops: the release cycle advances; the next op re-enters from RUN on the following cycle.

## Structure
- `hazard_ctrl_pkg`:
  - state enum (RUN, MDU);
  - `ZERO_REG` constant;
  - the `stage_ctrl_t` struct (we, kill) used for each stage output group.
- Sub-module `mdu_wait_cnt`: loadable down-counter with load, dec, freeze and `is_zero`. Instantiated once.
- The remaining logic (hazard compare, priority mux, perf counter) stays in `hazard_ctrl`.

## Test plan
- Load-use: `ex_mem_read`=1, `ex_rd`=5, `id_rs1`=5 used -> one cycle with `pc_we`=0, `we_ifid`=0, `kill_idex`=1; next cycle defaults; `stall_cycles`=1. Repeat with `ex_rd`=0 -> no stall.
- Branch plus load-use in the same cycle -> `kill_ifid`=`kill_idex`=1, `pc_we`=1, no stall; `stall_cycles` unchanged.
- MDU with MDU_LAT=4 -> 3 cycles of `pc_we`=0 with `kill_exmem`=1; `mdu_busy` high 3 cycles; `mdu_last` on cycle 4; `stall_cycles`=3.
- `mem_stall` asserted for 2 cycles mid-MDU (MDU_LAT=4) -> all `we_*`=0 for those cycles; `mdu_last` arrives 2 cycles later; `stall_cycles`=5.
- `rst` asserted in MDU state -> next cycle RUN, `mdu_busy`=0, `stall_cycles`=0; the following MDU op takes the full MDU_LAT.
- Back-to-back MDU ops (MDU_LAT=2) -> stall, release, stall, release; `mdu_last` pulses twice, two cycles apart.
